// File: rtl/cacheline_adapter.sv
// cacheline_adapter: serves 256-bit cache line reads/writes as 4-beat 64-bit bmem bursts, one line in flight.
module cacheline_adapter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW = $clog2(BEATS);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam logic [2:0] IDLE = 3'd0, RD_CMD = 3'd1, RD_WAIT = 3'd2, WR_BEAT = 3'd3, RESP = 3'd4;

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] r_dfp_rdata;
    logic              r_dfp_resp;
    logic [ADDR_W-1:0] r_bmem_addr;
    logic              r_bmem_read;
    logic              r_bmem_write;
    logic [BEAT_W-1:0] r_bmem_wdata;
    logic [LINE_W-1:0] w_fill;
    logic [ADDR_W-1:0] w_addr;
    logic [CW-1:0]     w_next_cnt;
    logic              w_last;
    logic              w_hit;
    logic              w_unused;

    assign w_addr     = {dfp_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign w_unused   = ^dfp_addr[OFF-1:0];
    assign w_next_cnt = r_cnt + 1'b1;
    assign w_last     = r_cnt == CW'(BEATS - 1);
    // r_bmem_addr doubles as the latched line address used to tag-match returning beats
    assign w_hit      = bmem_rvalid && bmem_raddr == r_bmem_addr;

    always_comb begin
        w_fill = r_line;
        w_fill[r_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_dfp_rdata  <= '0;
            r_dfp_resp   <= 1'b0;
            r_bmem_addr  <= '0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dfp_write && bmem_ready) begin
                        r_state      <= WR_BEAT;
                        r_bmem_addr  <= w_addr;
                        r_line       <= dfp_wdata;
                        r_bmem_write <= 1'b1;
                        r_bmem_wdata <= dfp_wdata[BEAT_W-1:0];
                        r_cnt        <= '0;
                    end else if (dfp_read && bmem_ready) begin
                        r_state     <= RD_CMD;
                        r_bmem_addr <= w_addr;
                        r_bmem_read <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                RD_CMD: begin
                    r_bmem_read <= 1'b0;
                    r_state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (w_hit) begin
                        r_line <= w_fill;
                        r_cnt  <= w_next_cnt;
                        if (w_last) begin
                            r_state     <= RESP;
                            r_dfp_resp  <= 1'b1;
                            r_dfp_rdata <= w_fill;
                        end
                    end
                end
                WR_BEAT: begin
                    r_cnt        <= w_next_cnt;
                    r_bmem_wdata <= r_line[w_next_cnt*BEAT_W +: BEAT_W];
                    if (w_last) begin
                        r_bmem_write <= 1'b0;
                        r_dfp_resp   <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_dfp_resp <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dfp_rdata  = r_dfp_rdata;
    assign dfp_resp   = r_dfp_resp;
    assign bmem_addr  = r_bmem_addr;
    assign bmem_read  = r_bmem_read;
    assign bmem_write = r_bmem_write;
    assign bmem_wdata = r_bmem_wdata;
endmodule
